// File: rtl/sram_access_seq.sv
// -----------------------------------------------------------------------------
// sram_access_seq
//
// Sequences one SRAM access per request coming from the memory control FSM.
// Each accepted request walks through a precharge phase, a wordline (ACCESS)
// phase of WL_CYCLES cycles and a one-cycle COMPLETE phase. A behavioural
// model of the cell array is included so that writes and reads can be
// observed end to end through the registered read-data output.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset (clears state, fields, array)
//   valid      request strobe, sampled on the rising edge
//   rw         request type sampled with valid: 1 = write, 0 = read
//   addr       word address sampled with valid
//   din        write data sampled with valid
//   precharge  bitline precharge enable (PRECH phase)
//   wl         one-hot wordline enables (ACCESS phase)
//   we         write driver enable (ACCESS phase of a write)
//   sense_en   sense amplifier enable (ACCESS phase of a read)
//   dout       registered read data, updated only when a read commits
//   done       one-cycle completion pulse (COMPLETE phase)
//   busy       request in flight (PRECH/ACCESS); valid is not accepted
//   overrun    sticky flag: a valid arrived while busy
// -----------------------------------------------------------------------------
module sram_access_seq #(
   parameter int ADDR_W    = 4,
   parameter int DATA_W    = 8,
   parameter int WL_CYCLES = 2   // legal range 1..15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid,
   input  logic                  rw,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     din,
   output logic                  precharge,
   output logic [2**ADDR_W-1:0]  wl,
   output logic                  we,
   output logic                  sense_en,
   output logic [DATA_W-1:0]     dout,
   output logic                  done,
   output logic                  busy,
   output logic                  overrun
);

   localparam int DEPTH = 2**ADDR_W;

   // Counter is sized for the full legal WL_CYCLES range (max load 14).
   localparam logic [3:0] CNT_INIT = 4'(WL_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PRECH    = 2'd1,
      ACCESS   = 2'd2,
      COMPLETE = 2'd3
   } state_t;

   state_t              state_reg, state_next;
   logic [3:0]          cnt_reg, cnt_next;
   logic                rw_reg;
   logic [ADDR_W-1:0]   addr_reg;
   logic [DATA_W-1:0]   din_reg;
   logic [DATA_W-1:0]   dout_reg;
   logic                overrun_reg;
   logic                accept;   // latch a new request at this edge
   logic                commit;   // last ACCESS edge: write or read the array
   logic                busy_int;

   logic [DATA_W-1:0]   mem [DEPTH];

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      accept     = 1'b0;
      commit     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (valid) begin
               accept     = 1'b1;
               state_next = PRECH;
            end
         end
         PRECH: begin
            state_next = ACCESS;
            cnt_next   = CNT_INIT;
         end
         ACCESS: begin
            if (cnt_reg == 4'd0) begin
               commit     = 1'b1;
               state_next = COMPLETE;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         COMPLETE: begin
            // A request arriving here chains straight into PRECH.
            if (valid) begin
               accept     = 1'b1;
               state_next = PRECH;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // State, counter, latched request fields, read data and overrun flag
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         cnt_reg     <= 4'd0;
         rw_reg      <= 1'b0;
         addr_reg    <= '0;
         din_reg     <= '0;
         dout_reg    <= '0;
         overrun_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (accept) begin
            rw_reg   <= rw;
            addr_reg <= addr;
            din_reg  <= din;
         end
         if (commit && !rw_reg)
            dout_reg <= mem[addr_reg];
         if (valid && busy_int)
            overrun_reg <= 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // Cell array model. It clears on reset so an aborted write leaves no trace.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (commit && rw_reg) begin
         mem[addr_reg] <= din_reg;
      end
   end

   // -------------------------------------------------------------------------
   // Moore output decode from registered state and latched fields
   // -------------------------------------------------------------------------
   assign busy_int  = (state_reg == PRECH) || (state_reg == ACCESS);
   assign busy      = busy_int;
   assign precharge = (state_reg == PRECH);
   assign we        = (state_reg == ACCESS) &&  rw_reg;
   assign sense_en  = (state_reg == ACCESS) && !rw_reg;
   assign done      = (state_reg == COMPLETE);
   assign dout      = dout_reg;
   assign overrun   = overrun_reg;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_wl
         assign wl[gi] = (state_reg == ACCESS) && (addr_reg == ADDR_W'(gi));
      end
   endgenerate

endmodule
